// File: rtl/controller_token_sync_if.sv
// Handshake bundle between the token controller and its left/right stages,
// the error detector and the stage data register.
interface controller_token_sync_if;
   logic lreq;
   logic lack;
   logic lereq;
   logic leack;
   logic rreq;
   logic rack;
   logic rereq;
   logic reack;
   logic sample;
   logic err0;
   logic err1;
   logic lclk;

   // master: the controller itself; slave: the surrounding stages
   modport master (
      input  lreq, leack, rack, rereq, err0, err1,
      output lack, lereq, rreq, reack, sample, lclk
   );

   modport slave (
      output lreq, leack, rack, rereq, err0, err1,
      input  lack, lereq, rreq, reack, sample, lclk
   );
endinterface

// File: rtl/controller_token_sync.sv
// Speculative pipeline-stage token controller: captures left data, forwards it
// early, and re-captures on a detected timing error before confirming it final.
module controller_token_sync (
   input logic                    clk,
   input logic                    rst,
   controller_token_sync_if.master bus
);

   typedef enum logic [2:0] {
      StIdle,
      StCapture,
      StWaitLe,
      StSample,
      StCorrect,
      StRelease,
      StLack
   } state_e;

   state_e state_q, state_d;

   logic full_q, full_d;
   logic checked_q, checked_d;
   logic rreq_q, rreq_d;
   logic reack_q, reack_d;
   logic lack_q, lack_d;
   logic lereq_q, lereq_d;
   logic sample_q, sample_d;
   logic lclk_q, lclk_d;

   logic right_done;
   logic capture;

   // The held token is retired only once it has been confirmed final downstream.
   assign right_done = full_q && checked_q && !rreq_q && !bus.rack && !reack_q;
   assign capture    = (state_q == StIdle) && bus.lreq && !full_q && !rreq_q;

   // State register together with all registered outputs and flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         full_q    <= 1'b1;
         checked_q <= 1'b1;
         rreq_q    <= 1'b1;
         reack_q   <= 1'b0;
         lack_q    <= 1'b0;
         lereq_q   <= 1'b0;
         sample_q  <= 1'b0;
         lclk_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         full_q    <= full_d;
         checked_q <= checked_d;
         rreq_q    <= rreq_d;
         reack_q   <= reack_d;
         lack_q    <= lack_d;
         lereq_q   <= lereq_d;
         sample_q  <= sample_d;
         lclk_q    <= lclk_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (capture) state_d = StCapture;
         StCapture: state_d = StWaitLe;
         StWaitLe:  if (bus.leack) state_d = StSample;
         StSample: begin
            // Err1 wins when both rails are high.
            if (bus.err1) begin
               state_d = StCorrect;
            end else if (bus.err0) begin
               state_d = StRelease;
            end
         end
         StCorrect: state_d = StRelease;
         StRelease: if (!bus.err0 && !bus.err1) state_d = StLack;
         StLack:    if (!bus.lreq && !bus.leack) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      full_d    = full_q;
      checked_d = checked_q;
      if (right_done) begin
         full_d    = 1'b0;
         checked_d = 1'b0;
      end
      if (capture) begin
         full_d    = 1'b1;
         checked_d = 1'b0;
      end
      if ((state_q == StRelease) && (state_d == StLack)) begin
         checked_d = 1'b1;
      end

      rreq_d = rreq_q;
      if (rreq_q && bus.rack) begin
         rreq_d = 1'b0;
      end
      if (capture) begin
         rreq_d = 1'b1;
      end

      // Answer uses the settled flag so a fresh check is confirmed a cycle later.
      reack_d = bus.rereq && checked_q && !right_done;

      lclk_d   = (state_d == StCapture) || (state_d == StCorrect);
      sample_d = (state_d == StSample) || (state_d == StCorrect);
      lereq_d  = (state_d == StCapture) || (state_d == StWaitLe) ||
                 (state_d == StSample) || (state_d == StCorrect) ||
                 (state_d == StRelease);
      lack_d   = (state_d == StLack);
   end

   assign bus.lack   = lack_q;
   assign bus.lereq  = lereq_q;
   assign bus.rreq   = rreq_q;
   assign bus.reack  = reack_q;
   assign bus.sample = sample_q;
   assign bus.lclk   = lclk_q;

endmodule

// File: tb/tb_controller_token_sync.sv
// Randomized token-level bench for controller_token_sync; expected timing and
// pulse counts come from the handshake rules, not from the controller's internals.
module tb_controller_token_sync;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   controller_token_sync_if bus ();

   controller_token_sync dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks   = 0;
   int n_pass     = 0;
   int lclk_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count capture pulses away from the active edge.
   always @(negedge clk) begin
      if (bus.lclk === 1'b1) lclk_total <= lclk_total + 1;
   end

   // One token: retire the held token downstream, capture a new one from the
   // left, check it (optionally with an error) and acknowledge the left stage.
   task automatic run_token(input int lmode, input bit early_re, input int ekind);
      int base;
      int lat;
      if (lmode == 0) begin
         bus.lreq = 1'b1;
         repeat ($urandom_range(1, 3)) begin
            tick();
            check("held_lack", bus.lack, 0);
            check("held_lclk", bus.lclk, 0);
         end
      end
      bus.rereq = 1'b1;
      tick();
      check("reack_on_query", bus.reack, 1);
      bus.rack = 1'b1;
      tick();
      check("rreq_fall", bus.rreq, 0);
      check("no_early_lack", bus.lack, 0);
      bus.rack  = 1'b0;
      bus.rereq = 1'b0;
      base = lclk_total;
      // Retirement takes two edges after the drop; capture on the third.
      if (lmode == 0) begin
         lat = 3;
      end else if (lmode == 1) begin
         tick();
         bus.lreq = 1'b1;
         lat = 2;
      end else begin
         repeat (2 + $urandom_range(0, 2)) begin
            tick();
            check("idle_lclk", bus.lclk, 0);
         end
         bus.lreq = 1'b1;
         lat = 1;
      end
      for (int t = 1; t <= lat; t++) begin
         tick();
         check("capture_lclk", bus.lclk, (t == lat) ? 1 : 0);
      end
      check("capture_rreq", bus.rreq, 1);
      check("capture_lereq", bus.lereq, 1);
      check("capture_lack", bus.lack, 0);
      if (early_re) bus.rereq = 1'b1;
      repeat ($urandom_range(1, 3)) begin
         bus.err0 = 1'($urandom_range(0, 1));
         bus.err1 = 1'($urandom_range(0, 1));
         tick();
         check("wait_le_sample", bus.sample, 0);
         check("wait_le_lclk", bus.lclk, 0);
      end
      bus.err0  = 1'b0;
      bus.err1  = 1'b0;
      bus.leack = 1'b1;
      tick();
      check("sample_open", bus.sample, 1);
      repeat ($urandom_range(0, 2)) tick();
      check("sample_wait", bus.sample, 1);
      if (early_re) check("reack_unchecked", bus.reack, 0);
      bus.err0 = (ekind != 1);
      bus.err1 = (ekind != 0);
      tick();
      if (ekind == 0) begin
         check("noerr_sample_close", bus.sample, 0);
         check("noerr_lclk", bus.lclk, 0);
      end else begin
         check("err_recapture", bus.lclk, 1);
         check("err_sample_held", bus.sample, 1);
         tick();
         check("err_sample_close", bus.sample, 0);
         check("err_lclk_end", bus.lclk, 0);
      end
      repeat ($urandom_range(0, 2)) tick();
      check("release_lack", bus.lack, 0);
      if (early_re) check("release_reack", bus.reack, 0);
      bus.err0 = 1'b0;
      bus.err1 = 1'b0;
      tick();
      check("lack_rise", bus.lack, 1);
      check("lereq_fall", bus.lereq, 0);
      if (early_re) check("reack_pending", bus.reack, 0);
      tick();
      check("lack_hold", bus.lack, 1);
      if (early_re) check("reack_answer", bus.reack, 1);
      bus.lreq  = 1'b0;
      bus.leack = 1'b0;
      tick();
      check("lack_fall", bus.lack, 0);
      tick();
      check("lclk_pulses", lclk_total - base, (ekind == 0) ? 1 : 2);
   endtask

   initial begin
      rst       = 1'b0;
      bus.lreq  = 1'b0;
      bus.leack = 1'b0;
      bus.rack  = 1'b0;
      bus.rereq = 1'b0;
      bus.err0  = 1'b0;
      bus.err1  = 1'b0;
      tick();
      tick();
      check("rst_rreq", bus.rreq, 1);
      check("rst_lack", bus.lack, 0);
      check("rst_lereq", bus.lereq, 0);
      check("rst_reack", bus.reack, 0);
      check("rst_sample", bus.sample, 0);
      check("rst_lclk", bus.lclk, 0);
      rst = 1'b1;
      tick();
      check("post_rst_rreq", bus.rreq, 1);

      for (int i = 0; i < 24; i++) begin
         run_token(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
      end

      // Reset while the sampling window is open.
      bus.rereq = 1'b1;
      tick();
      bus.rack = 1'b1;
      tick();
      bus.rack  = 1'b0;
      bus.rereq = 1'b0;
      tick();
      tick();
      bus.lreq = 1'b1;
      tick();
      check("mid_capture_lclk", bus.lclk, 1);
      tick();
      bus.leack = 1'b1;
      tick();
      check("mid_sample_open", bus.sample, 1);
      rst = 1'b0;
      tick();
      check("mid_rst_sample", bus.sample, 0);
      check("mid_rst_lack", bus.lack, 0);
      check("mid_rst_lereq", bus.lereq, 0);
      check("mid_rst_reack", bus.reack, 0);
      check("mid_rst_rreq", bus.rreq, 1);
      rst       = 1'b1;
      bus.lreq  = 1'b0;
      bus.leack = 1'b0;
      tick();
      check("after_rst_rreq", bus.rreq, 1);
      check("after_rst_lclk", bus.lclk, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/controller_token_sync.md
CONTROLLER_TOKEN_SYNC -- requirements
Module: controller_token

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; all state changes on rising clk.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-low reset (0 = reset).
REQ-004 Lreq  input  1  left data request, 4-phase.
REQ-005 Lack  output  1  left data acknowledge.
REQ-006 LEreq  output  1  query to left stage: "is your data final?"
REQ-007 LEack  input  1  left stage confirms its data final.
REQ-008 Rreq  output  1  right data request, speculative.
REQ-009 Rack  input  1  right data acknowledge.
REQ-010 REreq  input  1  right stage query: "is this stage's data final?"
REQ-011 REack  output  1  confirms this stage's data final.
REQ-012 sample  output  1  opens the error-detection sampling window.
REQ-013 Err0  input  1  dual-rail error result, no error.
REQ-014 Err1  input  1  dual-rail error result, timing error.
REQ-015 lclk  output  1  one-cycle capture pulse to the stage data register.
REQ-016 All inputs are synchronous to clk; no synchronizers. All outputs are registered; response is one cycle after the triggering input is sampled.

Function
REQ-017 Internal flags: full (stage holds data), checked (error check resolved).
REQ-018 Left FSM states and transitions:
- IDLE: wait Lreq=1 and full=0 and Rreq=0 -> CAPTURE.
- CAPTURE: lclk=1 for one cycle; set full; clear checked; set Rreq=1 and LEreq=1 -> WAIT_LE.
- WAIT_LE: wait LEack=1 -> SAMPLE.
- SAMPLE: sample=1; wait Err0=1 or Err1=1; Err1=1 (including Err0=Err1=1) -> CORRECT, else -> RELEASE.
- CORRECT: lclk=1 for one cycle (re-capture) -> RELEASE.
- RELEASE: sample=0; wait Err0=0 and Err1=0; then set checked, Lack=1, LEreq=0 -> LACK.
- LACK: wait Lreq=0 and LEack=0; then Lack=0 -> IDLE.
REQ-019 Right handshake:
- While REreq=1 and checked=1, REack=1.
- When REreq=0, REack=0.
- REack is never raised while checked=0.
REQ-020 Rreq falls one cycle after Rack=1 is sampled.
REQ-021 full and checked clear when Rreq=0, Rack=0 and REack=0; only then may the next CAPTURE occur.
REQ-022 lclk is high for at most one cycle per event: exactly one pulse on an error-free token, exactly two on an error token.
REQ-023 Lreq=1 while full=1 is held off (no Lack, no lclk) until the right handshake completes.
REQ-024 Err inputs are ignored outside SAMPLE/RELEASE.
REQ-025 REreq arriving before checked=1 waits; it is answered the cycle after checked sets.
REQ-026 Simultaneous Lreq rise and right-side completion: clearing full takes effect first; CAPTURE follows on the next cycle.

Reset
REQ-027 rst=0 at a rising edge forces:
- outputs: Lack=0, LEreq=0, REack=0, sample=0, lclk=0, Rreq=1;
- state: full=1, checked=1, left FSM in IDLE.
REQ-028 Out of reset the stage holds one valid, already-checked token; Rreq=1 is the first output activity.
REQ-029 Reset asserted mid-operation aborts any handshake and restores the REQ-027 values on the same edge.

Verification
REQ-030 Release rst with Lreq=0 -> Rreq=1; REreq=1 gives REack=1 next cycle; Rack=1 gives Rreq=0; Rack=0 and REreq=0 give full=0.
REQ-031 Lreq=1 while token still held -> Lack and lclk stay 0 until right handshake completes; then exactly one lclk pulse, Rreq=1, LEreq=1.
REQ-032 No-error path: LEack=1 -> sample=1; Err0=1 -> sample=0, single lclk total; Err0=0 -> Lack=1, LEreq=0, checked=1.
REQ-033 Error path: Err1=1 during SAMPLE -> second one-cycle lclk pulse, then sample=0; Lack rises only after Err1=0.
REQ-034 REreq=1 raised before the check resolves -> REack=0 until checked=1, then REack=1 next cycle.
REQ-035 rst=0 asserted while sample=1 -> next edge gives sample=0, Lack=0, LEreq=0, REack=0, Rreq=1.
